// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit add/subtract: one 4-bit CLA step per clock, carry registered between nibbles.
// Optional signed-overflow output enabled by defining ADDSUB_OVERFLOW_EN.
module nibble_serial_addsub #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
`ifdef ADDSUB_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never depends on ready, and in_ready/out_valid are decoded from the state register only.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             sub_q, carry_q, cout_q;
  logic [CW-1:0]    count_q;
  logic [3:0]       a_n, b_n, g, p, sum_n;
  logic [4:0]       c;
  logic             last;
`ifdef ADDSUB_OVERFLOW_EN
  logic             ovf_q;
`endif

  // One CLA nibble; B is inverted here so subtract becomes A + ~B + 1 with carry seeded by sub.
  always_comb begin
    a_n   = a_q[{count_q, 2'b00} +: 4];
    b_n   = b_q[{count_q, 2'b00} +: 4] ^ {4{sub_q}};
    g     = a_n & b_n;
    p     = a_n ^ b_n;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum_n = p ^ c[3:0];
    last  = (count_q == CW'(NIB - 1));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          a_q      <= a;
          b_q      <= b;
          sub_q    <= sub;
          carry_q  <= sub;
          count_q  <= '0;
          result_q <= '0;
          cout_q   <= 1'b0;
`ifdef ADDSUB_OVERFLOW_EN
          ovf_q    <= 1'b0;
`endif
        end
        RUN: begin
          result_q[{count_q, 2'b00} +: 4] <= sum_n;
          carry_q <= c[4];
          count_q <= count_q + 1'b1;
          if (last) begin
            cout_q <= c[4];
`ifdef ADDSUB_OVERFLOW_EN
            ovf_q  <= c[3] ^ c[4];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
`ifdef ADDSUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub (WIDTH=16); ovf is checked when ADDSUB_OVERFLOW_EN is defined.
module tb_nibble_serial_addsub;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sub, out_valid, out_ready, cout, busy;
  logic [15:0] a, b, result;
  logic        ovf_w;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];  // {result, cout, ovf}

  nibble_serial_addsub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout),
`ifdef ADDSUB_OVERFLOW_EN
    .ovf(ovf_w),
`endif
    .busy(busy)
  );

`ifndef ADDSUB_OVERFLOW_EN
  assign ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [15:0] yy;
    logic [16:0] sum;
    logic        o;
    yy  = s ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {16'd0, s};
    o   = (x[15] == yy[15]) && (sum[15] != x[15]);
    return {sum[15:0], sum[16], o};
  endfunction

  // Called at a negedge while idle; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic s);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL start_ready: in_ready=%b required 1", in_ready);
    end
    a = x; b = y; sub = s; in_valid = 1'b1;
    exp_q.push_back(model(x, y, s));
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom_range(0, 65535)); b = 16'($urandom_range(0, 65535)); sub = 1'($urandom_range(0, 1));
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0000) begin
      errors++; $display("FAIL accept_state: busy=%b in_ready=%b result=%h required 1/0/0000", busy, in_ready, result);
    end
  endtask

  // Called at the negedge after the accept edge; returns at the negedge where out_valid is seen.
  task automatic collect(input string name);
    int j;
    logic [17:0] e;
    j = 0;
    while (out_valid !== 1'b1 && j < 20) begin
      @(negedge clk);
      j++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s_timeout: out_valid=%b after %0d cycles required 1", name, out_valid, j);
      return;
    end
    checks++;
    if (j != 4) begin
      errors++; $display("FAIL %s_latency: %0d edges after accept required 4", name, j);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s_unexpected: out_valid with empty expected queue", name);
      return;
    end
    e = exp_q.pop_front();
    if (result !== e[17:2] || cout !== e[1]) begin
      errors++; $display("FAIL %s_value: result=%h cout=%b required %h %b", name, result, cout, e[17:2], e[1]);
    end
`ifdef ADDSUB_OVERFLOW_EN
    checks++;
    if (ovf_w !== e[0]) begin
      errors++; $display("FAIL %s_ovf: ovf=%b required %b", name, ovf_w, e[0]);
    end
`endif
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s, input string name);
    start_op(x, y, s);
    collect(name);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_release: out_valid=%b in_ready=%b busy=%b required 0/1/0", name, out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0 || cout !== 1'b0 || ovf_w !== 1'b0) begin
      errors++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b result=%h cout=%b ovf=%b required 1/0/0/0000/0/0",
               in_ready, out_valid, busy, result, cout, ovf_w);
    end
  endtask

  task automatic test_add;
    run_op(16'h0005, 16'h000C, 1'b0, "add_small");
    run_op(16'hFFFF, 16'h0001, 1'b0, "add_ripple");
    run_op(16'hD00D, 16'h0000, 1'b0, "add_zero");
    for (int i = 0; i < 4; i++)
      run_op(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_sub;
    run_op(16'h0009, 16'h000C, 1'b1, "sub_borrow");
    run_op(16'h000C, 16'h0009, 1'b1, "sub_noborrow");
  endtask

  task automatic test_overflow;
    run_op(16'h7FFF, 16'h0001, 1'b0, "ovf_pos");
    run_op(16'h8000, 16'h0001, 1'b1, "ovf_neg");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, "ovf_none");
    run_op(16'h0000, 16'h8000, 1'b1, "ovf_subneg");
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    start_op(16'h1111, 16'h2222, 1'b0);
    collect("bp_first");
    a = 16'h0100; b = 16'h0001; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || result !== 16'h3333) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b busy=%b result=%h required 1/0/1/3333",
                 i, out_valid, in_ready, busy, result);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    exp_q.push_back(model(16'h0100, 16'h0001, 1'b1));
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || result !== 16'h0000) begin
      errors++; $display("FAIL bp_accept: busy=%b in_ready=%b result=%h required 1/0/0000", busy, in_ready, result);
    end
    collect("bp_pending");
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    start_op(16'h1234, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 16'h0000 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: in_ready=%b out_valid=%b busy=%b result=%h cout=%b required 1/0/0/0000/0",
               in_ready, out_valid, busy, result, cout);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL midrun_discard: out_valid=%b required 0", out_valid);
      end
    end
    run_op(16'h1234, 16'h1111, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: %0d expected results never produced, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_addsub.md
# nibble_serial_addsub

Sequential WIDTH-bit add/subtract unit that processes one 4-bit nibble per clock through a single 4-bit carry-lookahead stage, with a registered carry between nibbles. It is the subtract-capable, handshaked counterpart to the team's combinational 4-bit CLA adder. Datapath blocks use it when a wide adder is too costly and a few cycles of latency are acceptable. Operands are captured on a valid/ready input handshake, and the result is held on a valid/ready output handshake.

## Interface
Parameters:
- WIDTH, default 16: operand width; must be a multiple of 4, minimum 4.
- NIB, default WIDTH/4: number of nibble steps per operation; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  high only in IDLE.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  0: A+B; 1: A−B.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, mod 2^WIDTH.
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow; present only with ADDSUB_OVERFLOW_EN.
- busy  output  1  high in RUN and DONE.

## Operation
- States:
  - IDLE: in_ready=1.
  - RUN: count 0..NIB−1.
  - DONE: out_valid=1.
- IDLE → RUN when in_valid && in_ready at a rising edge. On that edge the block:
  - latches a, b and sub;
  - sets the carry register to sub;
  - clears count and the result register.
- Subtract is computed as A + ~B + 1: latched B is inverted when sub=1, and the carry seed is 1.
- RUN, each edge:
  - nibble[count] = A[count] + B'[count] + carry through the 4-bit CLA;
  - the nibble is written into result[4·count+3 : 4·count];
  - the carry register takes the nibble carry-out;
  - count increments.
- RUN → DONE on the edge processing count=NIB−1. On that edge:
  - cout takes the final carry;
  - ovf takes (carry into MSB) XOR (carry out of MSB).
- DONE → IDLE on the edge where out_ready=1.
- In DONE, in_valid is ignored. No accept occurs in the same cycle as the result handshake.
- result, cout and ovf stay stable from the DONE entry edge until the next accept. After that accept they are cleared.
- a, b and sub may change freely after the accept edge; only latched copies are used.
- rst=1 at any edge, including mid-RUN or in DONE:
  - state goes to IDLE;
  - count, carry, result, cout, ovf and out_valid go to 0;
  - busy goes to 0 and in_ready to 1;
  - the in-flight operation is discarded with no output.
- rst takes priority over both handshakes on the same edge.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, result=0, cout=0, ovf=0.
- Accept at edge E0: busy=1 and in_ready=0 after E0.
- out_valid=1 after edge E0+NIB; for WIDTH=16 this is 4 edges after the accept.
- With out_ready held high, IDLE is re-entered after E0+NIB+1. The next accept is possible at E0+NIB+2.
- Minimum initiation interval: NIB+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs, including in_ready.
- The critical path is one 4-bit CLA stage plus the B-invert mux. It is independent of WIDTH.

## Configuration
- ADDSUB_OVERFLOW_EN defined:
  - the ovf port and register exist;
  - the MSB carry-in is captured on the final RUN edge;
  - ovf=1 when the signed result is not representable in WIDTH bits.
- ADDSUB_OVERFLOW_EN undefined:
  - the ovf port, register and MSB carry-in capture are omitted;
  - all other behaviour and timing is identical.

## Test plan
All scenarios use WIDTH=16 with ADDSUB_OVERFLOW_EN defined.
- Add 0x0005+0x000C, sub=0, out_ready=1 → result 0x0011, cout 0, ovf 0; out_valid rises exactly 4 edges after the accept and lasts 1 cycle.
- Full carry ripple: 0xFFFF+0x0001 → result 0x0000, cout 1, ovf 0. Also 0xD00D+0x0000 → 0xD00D, cout 0.
- Subtract: 0x0009−0x000C → 0xFFFD, cout 0 (borrow). Then 0x000C−0x0009 → 0x0003, cout 1.
- Signed overflow: 0x7FFF+0x0001 → 0x8000, ovf 1. Then 0x8000−0x0001 → 0x7FFF, ovf 1. Then 0xFFFF+0xFFFF → 0xFFFE, ovf 0, cout 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands applied.
  - Required: result stays stable, in_ready=0, no new accept.
  - Required: raising out_ready returns the block to IDLE next edge, and the pending operands are accepted on the following edge.
- Reset mid-RUN: start 0x1234+0x1111, assert rst for 1 cycle after 2 RUN edges.
  - Required: the next cycle shows in_ready=1, out_valid=0, result=0.
  - Required: a following 0x1234+0x1111 yields 0x2345 with no leftover carry.
